// File: rtl/fft_pkg.sv
// Shared types and index helpers for the radix-2 FFT sequencer.
// Helpers take the address width as an argument so one package serves every N.
package fft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_FLUSH,
        ST_UNLOAD
    } state_e;

    // Reverse the low m bits of v; upper bits of the result are zero.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input int m);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < m) begin
                r = r | (((v >> (m - 1 - b)) & 32'd1) << b);
            end
        end
        return r;
    endfunction

    // Rotate the low m bits of v left by l (0 <= l < m).
    function automatic logic [31:0] rotl(input logic [31:0] v, input int l, input int m);
        logic [31:0] mask;
        logic [31:0] x;
        mask = (32'd1 << m) - 32'd1;
        x    = v & mask;
        return ((x << l) | (x >> (m - l))) & mask;
    endfunction

endpackage

// File: rtl/fft_sequencer_if.sv
// Sequencer-facing bundle: sample front end, bank/BFU/twiddle control, result stream.
// master = sequencer side, slave = surrounding datapath and test environment.
interface fft_sequencer_if #(
    parameter int M = 5
);
    logic         start;
    logic         inverse;
    logic         in_valid;
    logic         in_ready;
    logic         load_we;
    logic [M-1:0] load_adr;
    logic         rd_sel;
    logic [M-1:0] rd_adr_a;
    logic [M-1:0] rd_adr_b;
    logic [M-2:0] twiddle_adr;
    logic         twiddle_conj;
    logic         we0;
    logic         we1;
    logic [M-1:0] wr_adr_a;
    logic [M-1:0] wr_adr_b;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] out_adr;
    logic         out_last;
    logic         result_sel;
    logic         busy;
    logic         done;

    modport master (
        input  start, inverse, in_valid, out_ready,
        output in_ready, load_we, load_adr, rd_sel, rd_adr_a, rd_adr_b,
               twiddle_adr, twiddle_conj, we0, we1, wr_adr_a, wr_adr_b,
               out_valid, out_adr, out_last, result_sel, busy, done
    );

    modport slave (
        output start, inverse, in_valid, out_ready,
        input  in_ready, load_we, load_adr, rd_sel, rd_adr_a, rd_adr_b,
               twiddle_adr, twiddle_conj, we0, we1, wr_adr_a, wr_adr_b,
               out_valid, out_adr, out_last, result_sel, busy, done
    );
endinterface

// File: rtl/fft_addr_gen.sv
// Butterfly address generator: (level, index) -> source pair and twiddle index.
// Purely combinational, zero latency, no backpressure.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int M  = 5,
    parameter int LW = 3
) (
    input  logic [LW-1:0] level,
    input  logic [M-2:0]  index,
    output logic [M-1:0]  rd_adr_a,
    output logic [M-1:0]  rd_adr_b,
    output logic [M-2:0]  twiddle_adr
);

    always_comb begin
        rd_adr_a    = M'(rotl(32'({index, 1'b0}), int'(level), M));
        rd_adr_b    = M'(rotl(32'({index, 1'b1}), int'(level), M));
        // Keep only the top `level` bits of the index: stride halves every level.
        twiddle_adr = (M-1)'(32'(index) & ~((32'd1 << (M - 1 - int'(level))) - 32'd1));
    end

endmodule

// File: rtl/fft_sequencer.sv
// FFT control sequencer: bit-reversed load, M butterfly levels with BFU_LAT-cycle write-back, natural-order unload.
// Load and unload stall on in_valid/out_ready; compute runs free, flushing BFU_LAT cycles between levels.
module fft_sequencer
    import fft_pkg::*;
#(
    parameter int N       = 32,
    parameter int M       = $clog2(N),
    parameter int BFU_LAT = 2
) (
    input  logic            clk,
    input  logic            reset_n,
    fft_sequencer_if.master bus
);

    localparam int   LW         = $clog2(M + 1);
    localparam int   FW         = $clog2(BFU_LAT + 1);
    localparam int   LAST       = BFU_LAT - 1;
    localparam logic RESULT_SEL = ((M - 1) % 2) == 0;

    state_e        state_q, state_d;
    logic [M-1:0]  cnt_q, cnt_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          inv_q, inv_d;
    logic          done_q, done_d;

    logic [BFU_LAT-1:0] dl_vld_q, dl_vld_d;
    logic [BFU_LAT-1:0] dl_sel_q, dl_sel_d;
    logic [M-1:0]       dl_a_q [BFU_LAT];
    logic [M-1:0]       dl_a_d [BFU_LAT];
    logic [M-1:0]       dl_b_q [BFU_LAT];
    logic [M-1:0]       dl_b_d [BFU_LAT];

    logic         rd_en;
    logic [M-1:0] gen_a, gen_b;
    logic [M-2:0] gen_tw;

    fft_addr_gen #(.M(M), .LW(LW)) u_addr_gen (
        .level       (lvl_q),
        .index       (cnt_q[M-2:0]),
        .rd_adr_a    (gen_a),
        .rd_adr_b    (gen_b),
        .twiddle_adr (gen_tw)
    );

    assign rd_en = (state_q == ST_COMPUTE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = lvl_q;
        fcnt_d  = fcnt_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    inv_d   = bus.inverse;
                end
            end
            ST_LOAD: begin
                if (bus.in_valid) begin
                    if (cnt_q == M'(N - 1)) begin
                        state_d = ST_COMPUTE;
                        cnt_d   = '0;
                        lvl_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                if (cnt_q == M'(N / 2 - 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                // Next level may only read once the last result of this one is written.
                if (fcnt_q == FW'(BFU_LAT - 1)) begin
                    fcnt_d = '0;
                    if (lvl_q == LW'(M - 1)) begin
                        state_d = ST_UNLOAD;
                        lvl_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_COMPUTE;
                        lvl_d   = lvl_q + 1'b1;
                    end
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (bus.out_ready) begin
                    if (cnt_q == M'(N - 1)) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dl_vld_d    = dl_vld_q;
        dl_sel_d    = dl_sel_q;
        dl_a_d      = dl_a_q;
        dl_b_d      = dl_b_q;
        dl_vld_d[0] = rd_en;
        dl_sel_d[0] = rd_en & lvl_q[0];
        dl_a_d[0]   = rd_en ? gen_a : '0;
        dl_b_d[0]   = rd_en ? gen_b : '0;
        for (int j = 1; j < BFU_LAT; j++) begin
            dl_vld_d[j] = dl_vld_q[j-1];
            dl_sel_d[j] = dl_sel_q[j-1];
            dl_a_d[j]   = dl_a_q[j-1];
            dl_b_d[j]   = dl_b_q[j-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            lvl_q    <= '0;
            fcnt_q   <= '0;
            inv_q    <= 1'b0;
            done_q   <= 1'b0;
            dl_vld_q <= '0;
            dl_sel_q <= '0;
            dl_a_q   <= '{default: '0};
            dl_b_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            lvl_q    <= lvl_d;
            fcnt_q   <= fcnt_d;
            inv_q    <= inv_d;
            done_q   <= done_d;
            dl_vld_q <= dl_vld_d;
            dl_sel_q <= dl_sel_d;
            dl_a_q   <= dl_a_d;
            dl_b_q   <= dl_b_d;
        end
    end

    assign bus.in_ready     = (state_q == ST_LOAD);
    assign bus.load_we      = (state_q == ST_LOAD) && bus.in_valid;
    assign bus.load_adr     = (state_q == ST_LOAD) ? M'(bitrev(32'(cnt_q), M)) : '0;
    assign bus.rd_sel       = rd_en & lvl_q[0];
    assign bus.rd_adr_a     = rd_en ? gen_a : '0;
    assign bus.rd_adr_b     = rd_en ? gen_b : '0;
    assign bus.twiddle_adr  = rd_en ? gen_tw : '0;
    assign bus.twiddle_conj = inv_q;
    // Results always land in the bank not being read at that level.
    assign bus.we0          = dl_vld_q[LAST] & dl_sel_q[LAST];
    assign bus.we1          = dl_vld_q[LAST] & ~dl_sel_q[LAST];
    assign bus.wr_adr_a     = dl_a_q[LAST];
    assign bus.wr_adr_b     = dl_b_q[LAST];
    assign bus.out_valid    = (state_q == ST_UNLOAD);
    assign bus.out_adr      = (state_q == ST_UNLOAD) ? cnt_q : '0;
    assign bus.out_last     = (state_q == ST_UNLOAD) && (cnt_q == M'(N - 1));
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.result_sel   = (state_q != ST_IDLE) & RESULT_SEL;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_fft_sequencer.sv
// Bench: two sequencers (N=32/LAT=2 and N=8/LAT=1) share stimulus; a timeline model predicts every output each cycle.
module tb_fft_sequencer;

    typedef struct packed {
        int in_ready, load_we, load_adr, rd_sel, rd_a, rd_b, tw, conj, we0, we1,
            wr_a, wr_b, out_valid, out_adr, out_last, result_sel, busy, done;
    } obs_t;

    // ph: 0 idle, 1 loading, 2 compute timeline, 3 unloading
    typedef struct packed {
        int ph, k, t, u, inv, done_p;
    } mst_t;

    string nm [18] = '{"in_ready", "load_we", "load_adr", "rd_sel", "rd_adr_a", "rd_adr_b",
                       "twiddle_adr", "twiddle_conj", "we0", "we1", "wr_adr_a", "wr_adr_b",
                       "out_valid", "out_adr", "out_last", "result_sel", "busy", "done"};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, inverse = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    int   tests = 0, fails = 0;
    mst_t ma = '0, mb = '0;

    always #5 clk = ~clk;

    fft_sequencer_if #(.M(5)) ifa ();
    fft_sequencer_if #(.M(3)) ifb ();

    assign ifa.start = start;  assign ifa.inverse = inverse;
    assign ifa.in_valid = in_valid;  assign ifa.out_ready = out_ready;
    assign ifb.start = start;  assign ifb.inverse = inverse;
    assign ifb.in_valid = in_valid;  assign ifb.out_ready = out_ready;

    fft_sequencer #(.N(32), .BFU_LAT(2)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ifa));
    fft_sequencer #(.N(8),  .BFU_LAT(1)) dut_b (.clk(clk), .reset_n(rst_n), .bus(ifb));

    function automatic int b2i(input bit x);
        return x ? 1 : 0;
    endfunction

    function automatic int ilog2(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int brev(input int v, input int m);
        int r = 0;
        int x = v;
        for (int b = 0; b < m; b++) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int rotl(input int v, input int l, input int m);
        return (v * (1 << l)) % (1 << m) + v / (1 << (m - l));
    endfunction

    // Expected outputs from the schedule: compute is a fixed timeline of M blocks of (N/2 reads + LAT gap).
    function automatic obs_t model_out(input int n, input int lat, input mst_t s, input bit iv);
        obs_t o;
        int m, h, p, l, r, sw;
        o = '0;
        m = ilog2(n);  h = n / 2;  p = h + lat;
        o.conj       = s.inv;
        o.busy       = b2i(s.ph != 0);
        o.result_sel = b2i(s.ph != 0 && (m - 1) % 2 == 0);
        case (s.ph)
            0: o.done = s.done_p;
            1: begin
                o.in_ready = 1;
                o.load_we  = b2i(iv);
                o.load_adr = brev(s.k, m);
            end
            2: begin
                l = s.t / p;  r = s.t % p;
                if (r < h) begin
                    o.rd_sel = l % 2;
                    o.rd_a   = rotl(2 * r, l, m);
                    o.rd_b   = rotl(2 * r + 1, l, m);
                    o.tw     = r - r % (1 << (m - 1 - l));
                end
                sw = s.t - lat;
                if (sw >= 0 && sw % p < h) begin
                    l = sw / p;  r = sw % p;
                    o.we0  = l % 2;
                    o.we1  = 1 - l % 2;
                    o.wr_a = rotl(2 * r, l, m);
                    o.wr_b = rotl(2 * r + 1, l, m);
                end
            end
            default: begin
                o.out_valid = 1;
                o.out_adr   = s.u;
                o.out_last  = b2i(s.u == n - 1);
            end
        endcase
        return o;
    endfunction

    function automatic mst_t model_next(input int n, input int lat, input mst_t s,
                                        input bit st, input bit inv, input bit iv, input bit ordy);
        mst_t x = s;
        case (s.ph)
            0: begin
                x.done_p = 0;
                if (st) begin x.ph = 1; x.k = 0; x.inv = b2i(inv); end
            end
            1: if (iv) begin
                x.k = s.k + 1;
                if (x.k == n) begin x.ph = 2; x.t = 0; end
            end
            2: begin
                x.t = s.t + 1;
                if (x.t == ilog2(n) * (n / 2 + lat)) begin x.ph = 3; x.u = 0; end
            end
            default: if (ordy) begin
                x.u = s.u + 1;
                if (x.u == n) begin x.ph = 0; x.done_p = 1; end
            end
        endcase
        return x;
    endfunction

    task automatic cmp_all(input string d, input obs_t a, input obs_t e);
        for (int j = 0; j < 18; j++) begin
            int av, ev;
            av = a[(17 - j) * 32 +: 32];
            ev = e[(17 - j) * 32 +: 32];
            tests++;
            if (av != ev) begin
                fails++;
                if (fails <= 40)
                    $display("FAIL %s.%s actual=%0d expected=%0d at %0t", d, nm[j], av, ev, $time);
            end
        end
    endtask

    task automatic lit(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        e = rst_n ? model_out(32, 2, ma, in_valid) : '0;
        a.in_ready = int'(ifa.in_ready);    a.load_we = int'(ifa.load_we);
        a.load_adr = int'(ifa.load_adr);    a.rd_sel = int'(ifa.rd_sel);
        a.rd_a = int'(ifa.rd_adr_a);        a.rd_b = int'(ifa.rd_adr_b);
        a.tw = int'(ifa.twiddle_adr);       a.conj = int'(ifa.twiddle_conj);
        a.we0 = int'(ifa.we0);              a.we1 = int'(ifa.we1);
        a.wr_a = int'(ifa.wr_adr_a);        a.wr_b = int'(ifa.wr_adr_b);
        a.out_valid = int'(ifa.out_valid);  a.out_adr = int'(ifa.out_adr);
        a.out_last = int'(ifa.out_last);    a.result_sel = int'(ifa.result_sel);
        a.busy = int'(ifa.busy);            a.done = int'(ifa.done);
        cmp_all("A", a, e);
        e = rst_n ? model_out(8, 1, mb, in_valid) : '0;
        a.in_ready = int'(ifb.in_ready);    a.load_we = int'(ifb.load_we);
        a.load_adr = int'(ifb.load_adr);    a.rd_sel = int'(ifb.rd_sel);
        a.rd_a = int'(ifb.rd_adr_a);        a.rd_b = int'(ifb.rd_adr_b);
        a.tw = int'(ifb.twiddle_adr);       a.conj = int'(ifb.twiddle_conj);
        a.we0 = int'(ifb.we0);              a.we1 = int'(ifb.we1);
        a.wr_a = int'(ifb.wr_adr_a);        a.wr_b = int'(ifb.wr_adr_b);
        a.out_valid = int'(ifb.out_valid);  a.out_adr = int'(ifb.out_adr);
        a.out_last = int'(ifb.out_last);    a.result_sel = int'(ifb.result_sel);
        a.busy = int'(ifb.busy);            a.done = int'(ifb.done);
        cmp_all("B", a, e);
        if (rst_n) begin
            ma = model_next(32, 2, ma, start, inverse, in_valid, out_ready);
            mb = model_next(8, 1, mb, start, inverse, in_valid, out_ready);
        end else begin
            ma = '0;
            mb = '0;
        end
    end

    initial begin
        int cyc, first_rd, first_we, hs, n;
        bit found, tog;

        // Model pins: hand-computed index arithmetic.
        lit("model_brev_1", brev(1, 5), 16);
        lit("model_rotl_l1", rotl(3, 1, 5), 6);
        lit("model_rotl_l4", rotl(30, 4, 5), 15);

        @(negedge clk);
        lit("reset_busy", int'(ifa.busy), 0);
        lit("reset_in_ready", int'(ifa.in_ready), 0);
        #2 rst_n = 1'b1;

        // Directed run: inverse FFT, continuous input, 1010 output acceptance.
        @(posedge clk); #1 start = 1'b1; inverse = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0; inverse = 1'b0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k == 1)  lit("load_adr_k1", int'(ifa.load_adr), 16);
            if (k == 3)  lit("load_adr_k3", int'(ifa.load_adr), 24);
            if (k == 31) lit("load_adr_k31", int'(ifa.load_adr), 31);
            @(posedge clk); #1;
        end
        cyc = 0; first_rd = -1; first_we = -1; found = 1'b0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            if (ifa.out_valid) begin
                found = 1'b1;
            end else begin
                if (cyc == 0) begin
                    lit("in_ready_after_load", int'(ifa.in_ready), 0);
                    lit("busy_in_compute", int'(ifa.busy), 1);
                    lit("l0_i0_tw", int'(ifa.twiddle_adr), 0);
                end
                if (first_rd < 0 && ifa.rd_adr_b == 5'd1) first_rd = cyc;
                if (first_we < 0 && ifa.we1) first_we = cyc;
                if (cyc == 19) begin
                    lit("l1_i1_rd_a", int'(ifa.rd_adr_a), 4);
                    lit("l1_i1_rd_b", int'(ifa.rd_adr_b), 6);
                    lit("l1_rd_sel", int'(ifa.rd_sel), 1);
                end
                if (cyc == 87) begin
                    lit("l4_i15_rd_a", int'(ifa.rd_adr_a), 15);
                    lit("l4_i15_rd_b", int'(ifa.rd_adr_b), 31);
                    lit("l4_i15_tw", int'(ifa.twiddle_adr), 15);
                end
                @(posedge clk); #1;
                start = (cyc == 40);
                cyc++;
            end
        end
        start = 1'b0;
        lit("compute_cycles", cyc, 90);
        lit("we1_delay", first_we - first_rd, 2);
        hs = 0; n = 0; tog = 1'b1;
        while (hs < 32 && n < 200) begin
            @(posedge clk); #1 out_ready = tog; tog = ~tog;
            @(negedge clk);
            if (n == 0) begin
                lit("unload_conj", int'(ifa.twiddle_conj), 1);
                lit("unload_result_sel", int'(ifa.result_sel), 1);
            end
            if (!out_ready) lit("out_adr_hold", int'(ifa.out_adr), hs);
            if (ifa.out_valid && out_ready) begin
                if (hs == 31) lit("out_last_31", int'(ifa.out_last), 1);
                hs++;
            end
            n++;
        end
        lit("unload_handshakes", hs, 32);
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        lit("done_pulse", int'(ifa.done), 1);
        lit("idle_after_done", int'(ifa.busy), 0);
        @(negedge clk);
        lit("done_one_cycle", int'(ifa.done), 0);

        // Asynchronous reset in the middle of level 2.
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (32 + 2 * 18 + 5) @(posedge clk);
        #1 lit("busy_before_reset", int'(ifa.busy), 1);
        #2 rst_n = 1'b0;
        #1;
        lit("rst_busy", int'(ifa.busy), 0);
        lit("rst_rd_adr_b", int'(ifa.rd_adr_b), 0);
        lit("rst_we", int'(ifa.we0) + int'(ifa.we1), 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Randomized traffic, including starts while busy and random inverse.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            start     = ($urandom % 6) == 0;
            inverse   = $urandom_range(0, 1) == 1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
